// File: rtl/pipeline_hazard_controller.sv
// Execute-stage sequencing controller: load-use stall insertion, taken-jump
// flush sequencing, ALU operand forwarding selects and saturating
// stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_occured,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  // Cycles still to flush after the detection cycle; the detection cycle
  // itself is the first flush cycle, so FLUSH holds FLUSH_CYCLES-1 cycles.
  localparam logic [2:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_t     state;
  logic [2:0] fcnt;
  logic       load_use;
  logic       jump_take;
  logic       stall_take;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Newest result wins: result_buf (1) over result_buf2 (2) over register file (0).
  function automatic logic [1:0] fwd_select(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] m_rd,
    input logic             m_we,
    input logic [REG_W-1:0] w_rd,
    input logic             w_we
  );
    if (m_we && (m_rd == src))      return 2'd1;
    else if (w_we && (w_rd == src)) return 2'd2;
    else                            return 2'd0;
  endfunction

  assign load_use = ex_mem_read && ex_reg_write &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // A jump seen during FLUSH belongs to a squashed instruction and is ignored.
  assign jump_take  = jump_occured && (state != FLUSH);
  // Hazard detection only runs in RUN so back-to-back bubbles never occur.
  assign stall_take = (state == RUN) && !jump_occured && load_use;

  assign fwd_a_sel = fwd_select(id_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b_sel = fwd_select(id_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

  // Pipeline register controls from current state and current inputs.
  always_comb begin
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    unique case (state)
      RUN: begin
        if (jump_occured) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
          idex_flush    = 1'b1;
        end
      end
      LOAD_STALL: begin
        if (jump_occured) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM sequencing, flush down-counter and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      fcnt        <= 3'd0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (jump_take)  flush_count <= sat_inc(flush_count);
      if (stall_take) stall_count <= sat_inc(stall_count);
      unique case (state)
        RUN, LOAD_STALL: begin
          if (jump_take) begin
            if (FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              fcnt  <= FCNT_INIT;
            end else begin
              state <= RUN;
            end
          end else if (stall_take) begin
            state <= LOAD_STALL;
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          if (fcnt == 3'd0) state <= RUN;
          else              fcnt  <= fcnt - 3'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: reset, load-use stall,
// jump flush, jump/hazard priority, forwarding, mid-sequence reset and
// counter saturation.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       jump_occured;
  logic [2:0] id_rs1, id_rs2;
  logic       id_uses_rs1, id_uses_rs2;
  logic [2:0] ex_rd;
  logic       ex_reg_write, ex_mem_read;
  logic [2:0] mem_rd;
  logic       mem_reg_write;
  logic [2:0] wb_rd;
  logic       wb_reg_write;

  logic        pc_write_en, ifid_write_en, ifid_flush, idex_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count, flush_count;

  // Second instance with single-cycle flush, used for saturation.
  logic        jump2;
  logic        pc_we2, ifid_we2, ifid_fl2, idex_fl2;
  logic [1:0]  fa2, fb2;
  logic [15:0] sc2, fc2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_W(3), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .jump_occured(jump_occured),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_controller #(.REG_W(3), .FLUSH_CYCLES(1)) u_sat (
    .clk(clk), .rst(rst), .jump_occured(jump2),
    .id_rs1(3'd0), .id_rs2(3'd0),
    .id_uses_rs1(1'b0), .id_uses_rs2(1'b0),
    .ex_rd(3'd0), .ex_reg_write(1'b0), .ex_mem_read(1'b0),
    .mem_rd(3'd0), .mem_reg_write(1'b0),
    .wb_rd(3'd0), .wb_reg_write(1'b0),
    .pc_write_en(pc_we2), .ifid_write_en(ifid_we2),
    .ifid_flush(ifid_fl2), .idex_flush(idex_fl2),
    .fwd_a_sel(fa2), .fwd_b_sel(fb2),
    .stall_count(sc2), .flush_count(fc2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    jump_occured = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    jump2 = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      jump_occured = 1'($urandom); id_rs1 = 3'($urandom); id_rs2 = 3'($urandom);
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); ex_rd = 3'($urandom);
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      mem_rd = 3'($urandom); mem_reg_write = 1'($urandom);
      wb_rd = 3'($urandom); wb_reg_write = 1'($urandom);
      cyc();
    end
    vectors++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got stall=%0h flush=%0h expected 0 0", stall_count, flush_count);
    end
    quiet();
    rst = 0;
    #1;
    vectors++;
    if ({pc_write_en, ifid_write_en, ifid_flush, idex_flush} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_quiet_ctrl: got %b expected 1100",
               {pc_write_en, ifid_write_en, ifid_flush, idex_flush});
    end
    cyc();
    vectors++;
    if ({pc_write_en, ifid_write_en, ifid_flush, idex_flush} !== 4'b1100 ||
        stall_count !== 16'd0 || flush_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_release: got ctrl=%b stall=%0h flush=%0h expected 1100 0 0",
               {pc_write_en, ifid_write_en, ifid_flush, idex_flush}, stall_count, flush_count);
    end
    // In RUN a load-use hazard must stall immediately.
    set_load_use();
    #1;
    vectors++;
    if (pc_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state_run: got pc_write_en=%b expected 0", pc_write_en);
    end
    cyc();
    quiet();
    cyc();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    vectors++;
    if ({pc_write_en, ifid_write_en, ifid_flush, idex_flush} !== 4'b0001) begin
      miscompares++;
      $display("FAIL load_use_stall: got %b expected 0001",
               {pc_write_en, ifid_write_en, ifid_flush, idex_flush});
    end
    cyc();
    #1;
    vectors++;
    if ({pc_write_en, ifid_write_en, ifid_flush, idex_flush} !== 4'b1100) begin
      miscompares++;
      $display("FAIL load_use_no_second: got %b expected 1100",
               {pc_write_en, ifid_write_en, ifid_flush, idex_flush});
    end
    vectors++;
    if (stall_count !== 16'd1) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d expected 1", stall_count);
    end
    cyc();
    ex_mem_read = 0; ex_reg_write = 0; mem_rd = 3; mem_reg_write = 1;
    #1;
    vectors++;
    if (fwd_a_sel !== 2'd1 || pc_write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL load_use_fwd: got fwd_a=%0d pc_we=%b expected 1 1", fwd_a_sel, pc_write_en);
    end
    cyc();
    vectors++;
    if (stall_count !== 16'd1) begin
      miscompares++;
      $display("FAIL load_use_count_hold: got %0d expected 1", stall_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pcw;
    do_reset();
    set_load_use();
    for (int i = 0; i < 6; i++) begin
      #1;
      pcw[i] = pc_write_en;
      cyc();
    end
    vectors++;
    if (pcw !== 6'b101010) begin
      miscompares++;
      $display("FAIL back_to_back_pattern: got %b expected 101010", pcw);
    end
    vectors++;
    if (stall_count !== 16'd3) begin
      miscompares++;
      $display("FAIL back_to_back_count: got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_jump();
    logic [3:0] fl;
    do_reset();
    jump_occured = 1;
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) jump_occured = 0;
      #1;
      fl[i] = ifid_flush & idex_flush & pc_write_en;
      vectors++;
      if (ifid_flush !== idex_flush || pc_write_en !== 1'b1) begin
        miscompares++;
        $display("FAIL jump_ctrl_c%0d: got ifid=%b idex=%b pc_we=%b expected equal flushes pc_we 1",
                 i, ifid_flush, idex_flush, pc_write_en);
      end
      cyc();
    end
    vectors++;
    if (fl !== 4'b0011) begin
      miscompares++;
      $display("FAIL jump_flush_len: got %b expected 0011", fl);
    end
    vectors++;
    if (flush_count !== 16'd1) begin
      miscompares++;
      $display("FAIL jump_count: got %0d expected 1", flush_count);
    end
    // Back in RUN: a fresh jump is honoured.
    jump_occured = 1;
    #1;
    vectors++;
    if (ifid_flush !== 1'b1) begin
      miscompares++;
      $display("FAIL jump_rerun: got ifid_flush=%b expected 1", ifid_flush);
    end
    cyc();
    jump_occured = 0;
    cyc();
    vectors++;
    if (flush_count !== 16'd2 || ifid_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_rerun_count: got count=%0d flush=%b expected 2 0", flush_count, ifid_flush);
    end
  endtask

  task automatic test_jump_and_hazard();
    do_reset();
    set_load_use();
    jump_occured = 1;
    #1;
    vectors++;
    if ({pc_write_en, ifid_write_en, ifid_flush, idex_flush} !== 4'b1111) begin
      miscompares++;
      $display("FAIL jump_hazard_ctrl: got %b expected 1111",
               {pc_write_en, ifid_write_en, ifid_flush, idex_flush});
    end
    cyc();
    quiet();
    #1;
    vectors++;
    if (stall_count !== 16'd0 || flush_count !== 16'd1) begin
      miscompares++;
      $display("FAIL jump_hazard_counts: got stall=%0d flush=%0d expected 0 1", stall_count, flush_count);
    end
    cyc();
  endtask

  task automatic test_forwarding();
    quiet();
    mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1; id_rs2 = 5; id_rs1 = 2;
    #1;
    vectors++;
    if (fwd_b_sel !== 2'd1 || fwd_a_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL fwd_both: got a=%0d b=%0d expected 0 1", fwd_a_sel, fwd_b_sel);
    end
    mem_reg_write = 0;
    #1;
    vectors++;
    if (fwd_b_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL fwd_wb_only: got %0d expected 2", fwd_b_sel);
    end
    wb_reg_write = 0;
    #1;
    vectors++;
    if (fwd_b_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL fwd_none: got %0d expected 0", fwd_b_sel);
    end
    mem_rd = 2; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    #1;
    vectors++;
    if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL fwd_split: got a=%0d b=%0d expected 1 2", fwd_a_sel, fwd_b_sel);
    end
    quiet();
    cyc();
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    jump_occured = 1;
    cyc();
    jump_occured = 0;
    #1;
    vectors++;
    if (ifid_flush !== 1'b1 || flush_count !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_flush_pre: got flush=%b count=%0d expected 1 1", ifid_flush, flush_count);
    end
    rst = 1;
    #1;
    vectors++;
    if (ifid_flush !== 1'b0 || idex_flush !== 1'b0 || flush_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_flush_rst: got ifid=%b idex=%b count=%0d expected 0 0 0",
               ifid_flush, idex_flush, flush_count);
    end
    cyc();
    rst = 0;
    cyc();
    vectors++;
    if (ifid_flush !== 1'b0 || idex_flush !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_flush_after: got ifid=%b idex=%b expected 0 0", ifid_flush, idex_flush);
    end
    // Reset out of LOAD_STALL: the held hazard stalls again straight away.
    set_load_use();
    cyc();
    rst = 1;
    #1;
    vectors++;
    if (stall_count !== 16'd0 || pc_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_rst: got count=%0d pc_we=%b expected 0 0", stall_count, pc_write_en);
    end
    cyc();
    rst = 0;
    quiet();
    cyc();
  endtask

  task automatic test_saturation();
    do_reset();
    jump2 = 1;
    #1;
    vectors++;
    if (ifid_fl2 !== 1'b1 || idex_fl2 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_flush1: got ifid=%b idex=%b expected 1 1", ifid_fl2, idex_fl2);
    end
    cyc();
    vectors++;
    if (fc2 !== 16'd1) begin
      miscompares++;
      $display("FAIL sat_first: got %0d expected 1", fc2);
    end
    for (int i = 0; i < 65534; i++) cyc();
    vectors++;
    if (fc2 !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %0h expected ffff", fc2);
    end
    for (int i = 0; i < 10; i++) cyc();
    vectors++;
    if (fc2 !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got %0h expected ffff", fc2);
    end
    jump2 = 0;
    #1;
    vectors++;
    if (ifid_fl2 !== 1'b0 || idex_fl2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_single_flush: got ifid=%b idex=%b expected 0 0", ifid_fl2, idex_fl2);
    end
    cyc();
  endtask

  initial begin
    quiet();
    rst = 1;
    #3;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_jump();
    test_jump_and_hazard();
    test_forwarding();
    test_reset_mid_sequence();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
